risc16_spi_mem: RTL and testbench

Memory responder for the `risc16` core. It serves both core ports, instruction fetch (`pc`/`instr`) and data (`dmem_*`), from a single external 23LC1024-style SPI SRAM. It stalls the core through `cpu_ena` and gives exactly one commit pulse per instruction. It sits between the core and the Tiny Tapeout I/O pins.

---
 rtl/risc16_mem_pkg.sv | 27 ++
 rtl/spi_frame_shifter.sv | 64 ++++++
 rtl/risc16_spi_mem.sv | 117 +++++++++++
 tb/tb_risc16_spi_mem.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc16_mem_pkg.sv
// Shared constants, types and helpers for the risc16 SPI SRAM memory responder.
package risc16_mem_pkg;

    localparam logic [7:0] SPI_READ   = 8'h03;
    localparam logic [7:0] SPI_WRITE  = 8'h02;
    localparam int         FRAME_BITS = 48;
    localparam logic [6:0] FRAME_LAST = 7'(2 * FRAME_BITS - 1);
    localparam logic [5:0] FRAME_MSB  = 6'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        FETCH,
        DECIDE,
        DATA,
        COMMIT
    } mem_state_t;

    function automatic logic [23:0] word_to_byte_addr(input logic [15:0] word_addr);
        return {7'b0, word_addr, 1'b0};
    endfunction

    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0]  cmd,
                                                         input logic [15:0] word_addr,
                                                         input logic [15:0] data);
        return {cmd, word_to_byte_addr(word_addr), data};
    endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// Runs one fixed 48-bit mode-0 SPI frame (96 clk cycles, SCK = clk/2) per start request.
module spi_frame_shifter
    import risc16_mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] tx_word,
    output logic                  done,
    output logic [15:0]           rx_word,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    logic        busy;
    logic [6:0]  bit_cnt;
    logic [15:0] rx_sr;
    logic [5:0]  next_bit;

    assign next_bit = bit_cnt[6:1] + 6'd1;
    assign done     = busy && (bit_cnt == FRAME_LAST);
    // Last MISO bit is folded in combinationally so the word lands in the caller's register on the final edge.
    assign rx_word  = {rx_sr[14:0], spi_miso};

    // tx_word is indexed live rather than latched: the fetch address only becomes valid after the
    // commit edge that starts the frame, and the first (command) bit does not depend on it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            bit_cnt  <= 7'd0;
            rx_sr    <= 16'h0000;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else if (!busy) begin
            if (start) begin
                busy     <= 1'b1;
                bit_cnt  <= 7'd0;
                spi_cs_n <= 1'b0;
                spi_sck  <= 1'b0;
                spi_mosi <= tx_word[FRAME_MSB];
            end
        end else if (done) begin
            busy     <= 1'b0;
            bit_cnt  <= 7'd0;
            rx_sr    <= rx_word;
            spi_cs_n <= 1'b1;
            spi_sck  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            bit_cnt <= bit_cnt + 7'd1;
            if (!bit_cnt[0]) begin
                spi_sck <= 1'b1;
            end else begin
                spi_sck  <= 1'b0;
                spi_mosi <= tx_word[FRAME_MSB - next_bit];
                rx_sr    <= rx_word;
            end
        end
    end

endmodule

// File: rtl/risc16_spi_mem.sv
// Serves risc16 instruction fetch and data accesses from one SPI SRAM, committing once per instruction.
//
// state  | meaning
// FETCH  | READ frame at pc; received word loads instr
// DECIDE | one cs_n-high cycle; sample dmem_we / dmem_re
// DATA   | one frame at dmem_addr, then one cs_n-high cycle
// COMMIT | cpu_ena high for one cycle; next fetch frame starts
module risc16_spi_mem
    import risc16_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic [15:0] instr,
    input  logic [15:0] dmem_addr,
    input  logic [15:0] dmem_data_in,
    output logic [15:0] dmem_data_out,
    input  logic        dmem_we,
    input  logic        dmem_re,
    output logic        cpu_ena,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    mem_state_t            state;
    mem_state_t            state_next;
    logic                  op_write;
    logic                  is_write;
    logic                  frame_start;
    logic                  frame_done;
    logic [15:0]           frame_rx;
    logic [FRAME_BITS-1:0] frame_tx;
    logic                  load_instr;
    logic                  load_data;

    spi_frame_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (frame_start),
        .tx_word  (frame_tx),
        .done     (frame_done),
        .rx_word  (frame_rx),
        .spi_cs_n (spi_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // spi_cs_n doubles as the shifter-idle indication.
    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (frame_done) state_next = DECIDE;
            DECIDE:  state_next = (dmem_we || dmem_re) ? DATA : COMMIT;
            DATA:    if (spi_cs_n) state_next = COMMIT;
            COMMIT:  state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    // A store wins over a load when both are requested.
    assign is_write = (state == DECIDE) ? dmem_we : op_write;

    always_comb begin
        frame_start = 1'b0;
        load_instr  = 1'b0;
        load_data   = 1'b0;
        frame_tx    = make_frame(SPI_READ, pc, 16'h0000);
        case (state)
            FETCH: begin
                frame_start = spi_cs_n;
                load_instr  = frame_done;
            end
            DECIDE: begin
                frame_start = dmem_we || dmem_re;
                frame_tx    = is_write ? make_frame(SPI_WRITE, dmem_addr, dmem_data_in)
                                       : make_frame(SPI_READ, dmem_addr, 16'h0000);
            end
            DATA: begin
                frame_tx  = is_write ? make_frame(SPI_WRITE, dmem_addr, dmem_data_in)
                                     : make_frame(SPI_READ, dmem_addr, 16'h0000);
                load_data = frame_done && !op_write;
            end
            COMMIT: begin
                frame_start = 1'b1;
            end
            default: begin
                frame_start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr         <= 16'h0000;
            dmem_data_out <= 16'h0000;
            cpu_ena       <= 1'b0;
            op_write      <= 1'b0;
        end else begin
            if (load_instr) instr <= frame_rx;
            if (load_data) dmem_data_out <= frame_rx;
            if (state == DECIDE) op_write <= dmem_we;
            cpu_ena <= (state_next == COMMIT);
        end
    end

endmodule

// File: tb/tb_risc16_spi_mem.sv
// Randomized bench for risc16_spi_mem with an SPI SRAM responder and a per-instruction timing model.
module tb_risc16_spi_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = 16'h0000;
    logic [15:0] dmem_addr = 16'h0000;
    logic [15:0] dmem_data_in = 16'h0000;
    logic        dmem_we = 1'b0;
    logic        dmem_re = 1'b0;
    logic        spi_miso = 1'b0;
    logic [15:0] instr;
    logic [15:0] dmem_data_out;
    logic        cpu_ena;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;

    always #5 clk = ~clk;

    risc16_spi_mem dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .instr         (instr),
        .dmem_addr     (dmem_addr),
        .dmem_data_in  (dmem_data_in),
        .dmem_data_out (dmem_data_out),
        .dmem_we       (dmem_we),
        .dmem_re       (dmem_re),
        .cpu_ena       (cpu_ena),
        .spi_cs_n      (spi_cs_n),
        .spi_sck       (spi_sck),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso)
    );

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_commit = 0;
    int          last_period = 0;
    int          frames = 0;
    logic [7:0]  last_cmd = 8'h00;
    logic [23:0] last_addr = 24'h000000;
    logic [15:0] exp_instr = 16'h0000;
    logic [15:0] exp_dout = 16'h0000;
    logic [7:0]  sram_mem [0:131071];
    logic [7:0]  ref_mem  [0:131071];

    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_word(input logic [15:0] w);
        return {ref_mem[{w, 1'b0}], ref_mem[{w, 1'b1}]};
    endfunction

    task automatic check_reset_outputs();
        check("rst cs_n", 48'(spi_cs_n), 48'd1);
        check("rst sck", 48'(spi_sck), 48'd0);
        check("rst mosi", 48'(spi_mosi), 48'd0);
        check("rst cpu_ena", 48'(cpu_ena), 48'd0);
        check("rst instr", 48'(instr), 48'd0);
        check("rst dmem_data_out", 48'(dmem_data_out), 48'd0);
    endtask

    // SRAM responder: decodes command/address from MOSI, serves reads, performs byte writes.
    initial begin : sram_responder
        int          fc;
        int          i;
        logic [7:0]  cmd;
        logic [7:0]  wbuf;
        logic [23:0] a;
        logic [15:0] rw;
        fc = 0;
        cmd = 8'h00;
        wbuf = 8'h00;
        a = 24'h0;
        forever begin
            @(negedge clk);
            if (spi_cs_n) begin
                fc = 0;
                spi_miso = 1'b0;
            end else begin
                i = fc / 2;
                if (fc % 2 == 1) begin
                    if (i < 8) cmd = {cmd[6:0], spi_mosi};
                    else if (i < 32) a = {a[22:0], spi_mosi};
                    else if (cmd == 8'h02) begin
                        wbuf = {wbuf[6:0], spi_mosi};
                        if (i == 39) sram_mem[a[16:0]] = wbuf;
                        if (i == 47) sram_mem[a[16:0] + 17'd1] = wbuf;
                    end
                    if (i == 31) begin
                        last_cmd = cmd;
                        last_addr = a;
                        frames++;
                    end
                end else begin
                    spi_miso = 1'b0;
                    if (i >= 32 && cmd == 8'h03) begin
                        rw = {sram_mem[a[16:0]], sram_mem[a[16:0] + 17'd1]};
                        spi_miso = rw[4'(47 - i)];
                    end
                end
                fc++;
            end
        end
    end

    // One instruction: per-cycle expectations derived from the frame schedule of the instruction.
    task automatic run_instr(input logic [15:0] p, input logic w, input logic r,
                             input logic [15:0] da, input logic [15:0] dd, input int reset_at);
        logic        has_data;
        int          period;
        int          k;
        int          fc;
        int          rst_pt;
        logic        in_frame;
        logic        full;
        logic [47:0] fw;
        logic [47:0] dw;
        logic [47:0] fword;
        has_data = w || r;
        period = has_data ? 195 : 98;
        rst_pt = reset_at;
        @(posedge clk);
        #1;
        pc = p;
        dmem_we = w;
        dmem_re = r;
        dmem_addr = da;
        dmem_data_in = dd;
        fw = {8'h03, 7'b0, p, 1'b0, 16'h0000};
        dw = {(w ? 8'h02 : 8'h03), 7'b0, da, 1'b0, (w ? dd : 16'h0000)};
        k = 0;
        while (k < period) begin
            @(negedge clk);
            in_frame = 1'b0;
            full = 1'b0;
            fc = 0;
            fword = 48'h0;
            if (k < 96) begin
                in_frame = 1'b1;
                fc = k;
                fword = fw;
            end else if (has_data && k >= 97 && k < 193) begin
                in_frame = 1'b1;
                fc = k - 97;
                fword = dw;
                full = w;
            end
            if (k == 96) exp_instr = ref_word(p);
            if (k == 193 && r && !w) exp_dout = ref_word(da);
            if (in_frame) begin
                check("frame cs_n", 48'(spi_cs_n), 48'd0);
                check("frame sck", 48'(spi_sck), 48'(fc % 2));
                if (fc / 2 < 32 || full)
                    check("frame mosi", 48'(spi_mosi), 48'(fword[6'(47 - fc / 2)]));
            end else begin
                check("idle cs_n", 48'(spi_cs_n), 48'd1);
                check("idle sck", 48'(spi_sck), 48'd0);
            end
            check("cpu_ena", 48'(cpu_ena), 48'(k == period - 1));
            check("instr", 48'(instr), 48'(exp_instr));
            check("dmem_data_out", 48'(dmem_data_out), 48'(exp_dout));
            if (k == period - 1) begin
                if (w) begin
                    ref_mem[{da, 1'b0}] = dd[15:8];
                    ref_mem[{da, 1'b1}] = dd[7:0];
                end
                last_period = cyc - last_commit;
                last_commit = cyc;
            end
            if (k == rst_pt) begin
                rst_n = 1'b0;
                exp_instr = 16'h0000;
                exp_dout = 16'h0000;
                repeat (3) begin
                    @(negedge clk);
                    check_reset_outputs();
                end
                rst_n = 1'b1;
                rst_pt = -1;
                k = 0;
            end else begin
                k++;
            end
        end
    endtask

    initial begin : main
        logic [7:0]  b;
        logic [15:0] rp;
        logic [15:0] ra;
        logic [15:0] rd;
        int          sel;
        int          f0;
        int          mism;
        for (int i = 0; i < 131072; i++) begin
            b = 8'($urandom);
            sram_mem[17'(i)] = b;
            ref_mem[17'(i)] = b;
        end
        sram_mem[17'd10] = 8'h12;  ref_mem[17'd10] = 8'h12;
        sram_mem[17'd11] = 8'h34;  ref_mem[17'd11] = 8'h34;
        sram_mem[17'h10000] = 8'hBE;  ref_mem[17'h10000] = 8'hBE;
        sram_mem[17'h10001] = 8'hEF;  ref_mem[17'h10001] = 8'hEF;

        rst_n = 1'b0;
        pc = 16'h0005;
        repeat (5) begin
            @(negedge clk);
            check_reset_outputs();
        end
        rst_n = 1'b1;

        run_instr(16'h0005, 1'b0, 1'b0, 16'h0000, 16'h0000, -1);
        check("fetch cmd", 48'(last_cmd), 48'h03);
        check("fetch addr", 48'(last_addr), 48'h00000A);
        check("fetch instr", 48'(instr), 48'h1234);

        run_instr(16'h0006, 1'b0, 1'b1, 16'h8000, 16'h0000, -1);
        check("load cmd", 48'(last_cmd), 48'h03);
        check("load addr", 48'(last_addr), 48'h010000);
        check("load data", 48'(dmem_data_out), 48'hBEEF);
        check("load period", 48'(last_period), 48'd195);

        run_instr(16'h0007, 1'b1, 1'b0, 16'h0003, 16'hA55A, -1);
        check("store cmd", 48'(last_cmd), 48'h02);
        check("store addr", 48'(last_addr), 48'h000006);
        check("store byte6", 48'(sram_mem[17'd6]), 48'hA5);
        check("store byte7", 48'(sram_mem[17'd7]), 48'h5A);
        check("store dout held", 48'(dmem_data_out), 48'hBEEF);
        check("store period", 48'(last_period), 48'd195);

        f0 = frames;
        run_instr(16'h0008, 1'b1, 1'b1, 16'h0100, 16'h1357, -1);
        check("conflict cmd", 48'(last_cmd), 48'h02);
        check("conflict frames", 48'(frames - f0), 48'd2);
        check("conflict dout held", 48'(dmem_data_out), 48'hBEEF);
        check("conflict period", 48'(last_period), 48'd195);

        run_instr(16'h0009, 1'b0, 1'b0, 16'h0000, 16'h0000, -1);
        check("plain period", 48'(last_period), 48'd98);

        f0 = frames;
        run_instr(16'h0020, 1'b0, 1'b0, 16'h0000, 16'h0000, 40);
        check("reset refetch frames", 48'(frames - f0), 48'd1);
        check("reset refetch addr", 48'(last_addr), 48'h000040);

        for (int n = 0; n < 30; n++) begin
            rp = 16'($urandom);
            ra = 16'($urandom);
            rd = 16'($urandom);
            sel = int'($urandom_range(0, 3));
            run_instr(rp, (sel == 2 || sel == 3), (sel == 1 || sel == 3), ra, rd, -1);
        end

        mism = 0;
        for (int i = 0; i < 131072; i++)
            if (sram_mem[17'(i)] !== ref_mem[17'(i)]) mism++;
        check("sram contents", 48'(mism), 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
